// File: rtl/top_memory_access_pkg.sv
// Shared constants for the memory-access stage: decoded-op bit positions,
// FUNCT3 encodings, FSM state encoding and an access-width decode helper.
package top_memory_access_pkg;

   // Bit positions inside the decoded-op vector
   localparam int LOAD_BIT     = 3;
   localparam int STORE_BIT    = 4;
   localparam int FUNCT3_BIT_L = 0;
   localparam int FUNCT3_BIT_M = 2;

   // Load FUNCT3 encodings. Stores share the low-three encodings (SB=LB, SH=LH, SW=LW).
   localparam logic [2:0] FUNCT3_LB  = 3'b000;
   localparam logic [2:0] FUNCT3_LH  = 3'b001;
   localparam logic [2:0] FUNCT3_LW  = 3'b010;
   localparam logic [2:0] FUNCT3_LBU = 3'b100;
   localparam logic [2:0] FUNCT3_LHU = 3'b101;

   typedef enum logic [1:0] {
      MS_IDLE = 2'd0,
      MS_REQ  = 2'd1,
      MS_DONE = 2'd2
   } mem_state_e;

   typedef enum logic [1:0] {
      ACC_BYTE,
      ACC_HALF,
      ACC_WORD
   } access_size_e;

   // Any FUNCT3 that is not a byte or half encoding is handled as a word access
   function automatic access_size_e access_size(input logic [2:0] funct3);
      case (funct3)
         FUNCT3_LB, FUNCT3_LBU: return ACC_BYTE;
         FUNCT3_LH, FUNCT3_LHU: return ACC_HALF;
         FUNCT3_LW:             return ACC_WORD;
         default:               return ACC_WORD;
      endcase
   endfunction

endpackage

// File: rtl/top_memory_access_if.sv
// Data-memory bus: req/ack handshake with word address, byte enables and
// lane-replicated write data. The read word is valid in the ack cycle.
interface top_memory_access_if #(
   parameter int XLEN = 32
);
   logic            req;
   logic            we;
   logic [XLEN-1:0] addr;
   logic [3:0]      be;
   logic [XLEN-1:0] wdata;
   logic            ack;
   logic [XLEN-1:0] rdata;

   modport master (output req, we, addr, be, wdata, input ack, rdata);
   modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/top_memory_access_mem_lane_align.sv
// Byte-lane alignment for the memory stage: byte enables and replicated
// store data for stores, lane selection and sign/zero extension for loads.
// The misaligned flag is only reported when MEM_MISALIGN_TRAP_EN is defined;
// otherwise it is tied 0 and low address bits the width ignores are dropped.
module mem_lane_align
   import top_memory_access_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [1:0]      addr,
   input  logic [XLEN-1:0] rs2data,
   input  logic [XLEN-1:0] rdata,
   output logic [3:0]      be,
   output logic [XLEN-1:0] wdata,
   output logic [XLEN-1:0] load_data,
   output logic            misaligned
);

   access_size_e size;
   logic [7:0]   lane_byte;
   logic [15:0]  lane_half;
   logic         unsigned_load;

   assign size          = access_size(funct3);
   assign lane_byte     = rdata[{addr, 3'b000} +: 8];
   assign lane_half     = rdata[{addr[1], 4'b0000} +: 16];
   assign unsigned_load = funct3[2];

   // Lane steering per access width
   // NOTE: every output gets a default first so no path leaves one unassigned (no latches)
   always_comb begin
      be        = 4'b1111;
      wdata     = rs2data;
      load_data = rdata;
      case (size)
         ACC_BYTE: begin
            be        = 4'b0001 << addr;
            wdata     = {4{rs2data[7:0]}};
            load_data = {{(XLEN-8){lane_byte[7] & ~unsigned_load}}, lane_byte};
         end
         ACC_HALF: begin
            be        = 4'b0011 << {addr[1], 1'b0};
            wdata     = {2{rs2data[15:0]}};
            load_data = {{(XLEN-16){lane_half[15] & ~unsigned_load}}, lane_half};
         end
         default: begin
            be        = 4'b1111;
            wdata     = rs2data;
            load_data = rdata;
         end
      endcase
   end

`ifdef MEM_MISALIGN_TRAP_EN
   assign misaligned = ((size == ACC_HALF) && addr[0]) ||
                       ((size == ACC_WORD) && (addr != 2'b00));
`else
   assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/top_memory_access.sv
// Memory-access stage of the multi-cycle RV32I core. Runs loads/stores on the
// data-memory bus (IDLE -> REQ -> DONE), latches writeback results (*_mw) and
// raises stall_memory while a bus access is outstanding.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned accesses skip the
// bus, go IDLE -> DONE and latch misalign_mw=1 with the faulting address).
module top_memory_access
   import top_memory_access_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int OPLEN = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             phase_memory,
   input  logic [OPLEN-1:0] decoded_op_em,
   input  logic [XLEN-1:0]  alu_out_em,
   input  logic [XLEN-1:0]  rs2data_em,
   input  logic [4:0]       rdsel_em,
   input  logic [XLEN-1:0]  curr_pc_em,
   input  logic             jump_state_em,
   top_memory_access_if.master dmem,
   output logic [XLEN-1:0]  rd_data_mw,
   output logic [4:0]       rdsel_mw,
   output logic [OPLEN-1:0] decoded_op_mw,
   output logic [XLEN-1:0]  curr_pc_mw,
   output logic [XLEN-1:0]  alu_out_mw,
   output logic             jump_state_mw,
   output logic             misalign_mw,
   output logic             stall_memory
);

   mem_state_e      state;
   mem_state_e      state_next;

   logic            is_load;
   logic            is_store;
   logic            is_mem;
   logic [2:0]      funct3;

   logic [3:0]      lane_be;
   logic [XLEN-1:0] lane_wdata;
   logic [XLEN-1:0] load_data;
   logic            misaligned;

   logic            latch_en;
   logic            latch_misalign;
   logic [XLEN-1:0] latch_data;

   assign is_load  = decoded_op_em[LOAD_BIT];
   assign is_store = decoded_op_em[STORE_BIT];
   assign is_mem   = is_load | is_store;
   assign funct3   = decoded_op_em[FUNCT3_BIT_M:FUNCT3_BIT_L];

   mem_lane_align #(.XLEN(XLEN)) u_lane_align (
      .funct3     (funct3),
      .addr       (alu_out_em[1:0]),
      .rs2data    (rs2data_em),
      .rdata      (dmem.rdata),
      .be         (lane_be),
      .wdata      (lane_wdata),
      .load_data  (load_data),
      .misaligned (misaligned)
   );

   // FSM state register; reset drops straight back to IDLE, which also drops req
   // NOTE: sequential state uses non-blocking assignments so all flops update together
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= MS_IDLE;
      else        state <= state_next;
   end

   // Next state, bus drive, stall and writeback-latch control
   always_comb begin
      state_next     = state;
      stall_memory   = 1'b0;
      dmem.req       = 1'b0;
      dmem.we        = 1'b0;
      dmem.addr      = '0;
      dmem.be        = 4'b0000;
      dmem.wdata     = '0;
      latch_en       = 1'b0;
      latch_misalign = 1'b0;
      latch_data     = alu_out_em;
      case (state)
         MS_IDLE: begin
            if (phase_memory) begin
               if (is_mem) begin
                  stall_memory = 1'b1;
                  if (misaligned) begin
                     // Trap: no bus access, record the faulting address
                     latch_en       = 1'b1;
                     latch_misalign = 1'b1;
                     state_next     = MS_DONE;
                  end else begin
                     state_next = MS_REQ;
                  end
               end else begin
                  latch_en = 1'b1;
               end
            end
         end
         MS_REQ: begin
            // *_em inputs are held stable by the stall, so the bus is driven from them
            dmem.req     = 1'b1;
            dmem.we      = is_store;
            dmem.addr    = {alu_out_em[XLEN-1:2], 2'b00};
            dmem.be      = lane_be;
            dmem.wdata   = lane_wdata;
            stall_memory = 1'b1;
            if (dmem.ack) begin
               latch_en   = 1'b1;
               latch_data = is_load ? load_data : alu_out_em;
               state_next = MS_DONE;
            end
         end
         MS_DONE: state_next = MS_IDLE;
         default: state_next = MS_IDLE;
      endcase
   end

   // Writeback latch: captures the stage results whenever the FSM signals an update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_mw    <= '0;
         rdsel_mw      <= '0;
         decoded_op_mw <= '0;
         curr_pc_mw    <= '0;
         alu_out_mw    <= '0;
         jump_state_mw <= 1'b0;
         misalign_mw   <= 1'b0;
      end else if (latch_en) begin
         rd_data_mw    <= latch_data;
         rdsel_mw      <= rdsel_em;
         decoded_op_mw <= decoded_op_em;
         curr_pc_mw    <= curr_pc_em;
         alu_out_mw    <= alu_out_em;
         jump_state_mw <= jump_state_em;
         misalign_mw   <= latch_misalign;
      end
   end

endmodule

// File: tb/tb_top_memory_access.sv
// Self-checking bench for top_memory_access. Expected bus fields and
// writeback values come from a small arithmetic model of the load/store rules.
// Honours MEM_MISALIGN_TRAP_EN when the build defines it.
module tb_top_memory_access;
   import top_memory_access_pkg::*;

   localparam int XLEN  = 32;
   localparam int OPLEN = 16;
`ifdef MEM_MISALIGN_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             phase_memory = 1'b0;
   logic [OPLEN-1:0] decoded_op_em = '0;
   logic [XLEN-1:0]  alu_out_em = '0;
   logic [XLEN-1:0]  rs2data_em = '0;
   logic [4:0]       rdsel_em = '0;
   logic [XLEN-1:0]  curr_pc_em = '0;
   logic             jump_state_em = 1'b0;
   logic [XLEN-1:0]  rd_data_mw;
   logic [4:0]       rdsel_mw;
   logic [OPLEN-1:0] decoded_op_mw;
   logic [XLEN-1:0]  curr_pc_mw;
   logic [XLEN-1:0]  alu_out_mw;
   logic             jump_state_mw;
   logic             misalign_mw;
   logic             stall_memory;

   int n_checks = 0;
   int n_fail   = 0;

   top_memory_access_if #(.XLEN(XLEN)) dmem ();

   top_memory_access #(.XLEN(XLEN), .OPLEN(OPLEN)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .phase_memory  (phase_memory),
      .decoded_op_em (decoded_op_em),
      .alu_out_em    (alu_out_em),
      .rs2data_em    (rs2data_em),
      .rdsel_em      (rdsel_em),
      .curr_pc_em    (curr_pc_em),
      .jump_state_em (jump_state_em),
      .dmem          (dmem),
      .rd_data_mw    (rd_data_mw),
      .rdsel_mw      (rdsel_mw),
      .decoded_op_mw (decoded_op_mw),
      .curr_pc_mw    (curr_pc_mw),
      .alu_out_mw    (alu_out_mw),
      .jump_state_mw (jump_state_mw),
      .misalign_mw   (misalign_mw),
      .stall_memory  (stall_memory)
   );

   always #5 clk = ~clk;

   // Hard time limit so the run can never hang
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic int size_of(input logic [2:0] f3);
      if (f3 == 3'd0 || f3 == 3'd4) return 1;
      if (f3 == 3'd1 || f3 == 3'd5) return 2;
      return 4;
   endfunction

   function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [1:0] a);
      int sz = size_of(f3);
      if (sz == 1) return 4'(1 << a);
      if (sz == 2) return 4'(3 << (a & 2'd2));
      return 4'hF;
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] rs2);
      int sz = size_of(f3);
      if (sz == 1) return 32'(rs2[7:0]) * 32'h0101_0101;
      if (sz == 2) return 32'(rs2[15:0]) * 32'h0001_0001;
      return rs2;
   endfunction

   function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] rdata);
      int sz = size_of(f3);
      logic [31:0] v;
      if (sz == 1) begin
         v = (rdata >> (8 * int'(a))) & 32'hFF;
         if (f3 == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
         return v;
      end
      if (sz == 2) begin
         v = (rdata >> (16 * int'(a[1]))) & 32'hFFFF;
         if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
         return v;
      end
      return rdata;
   endfunction

   function automatic bit exp_mis(input logic [2:0] f3, input logic [1:0] a);
      int sz = size_of(f3);
      if (!TRAP_EN) return 1'b0;
      return (sz == 2 && a[0]) || (sz == 4 && a != 2'd0);
   endfunction

   // ---------------- one stage operation ----------------
   // Starts just after a negedge with the DUT in IDLE; returns at a negedge,
   // DUT in IDLE, phase_memory low.
   task automatic run_op(input string tag, input bit is_load, input bit is_store,
                         input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rs2, input logic [31:0] rdata,
                         input logic [4:0] rd, input int waits, input bit drop_phase);
      logic [OPLEN-1:0] op;
      logic [31:0] pc, exp_rd;
      bit jmp, mem, trap;
      op = OPLEN'($urandom);
      op[LOAD_BIT]  = is_load;
      op[STORE_BIT] = is_store;
      op[FUNCT3_BIT_M:FUNCT3_BIT_L] = f3;
      pc  = $urandom;
      jmp = 1'($urandom);
      mem  = is_load || is_store;
      trap = mem && exp_mis(f3, addr[1:0]);
      exp_rd = (is_load && !trap) ? exp_load(f3, addr[1:0], rdata) : addr;

      phase_memory = 1'b1; decoded_op_em = op; alu_out_em = addr; rs2data_em = rs2;
      rdsel_em = rd; curr_pc_em = pc; jump_state_em = jmp; dmem.ack = 1'b0;
      #1;
      // IDLE cycle
      n_checks++; if (dmem.req !== 1'b0) begin n_fail++; $display("FAIL %s idle_req: got %b want 0", tag, dmem.req); end
      n_checks++; if (stall_memory !== mem) begin n_fail++; $display("FAIL %s idle_stall: got %b want %b", tag, stall_memory, mem); end

      if (mem && !trap) begin
         for (int w = 0; w <= waits; w++) begin
            @(negedge clk);
            if (drop_phase && w == 0) phase_memory = 1'b0;
            dmem.ack   = (w == waits);
            dmem.rdata = (w == waits) ? rdata : $urandom;
            #1;
            n_checks++; if (dmem.req !== 1'b1) begin n_fail++; $display("FAIL %s req_high: cycle %0d got %b want 1", tag, w, dmem.req); end
            n_checks++; if (stall_memory !== 1'b1) begin n_fail++; $display("FAIL %s req_stall: cycle %0d got %b want 1", tag, w, stall_memory); end
            n_checks++; if (dmem.addr !== {addr[31:2], 2'b00}) begin n_fail++; $display("FAIL %s addr: got %h want %h", tag, dmem.addr, {addr[31:2], 2'b00}); end
            n_checks++; if (dmem.we !== is_store) begin n_fail++; $display("FAIL %s we: got %b want %b", tag, dmem.we, is_store); end
            n_checks++; if (dmem.be !== exp_be(f3, addr[1:0])) begin n_fail++; $display("FAIL %s be: got %b want %b", tag, dmem.be, exp_be(f3, addr[1:0])); end
            if (is_store) begin
               n_checks++; if (dmem.wdata !== exp_wdata(f3, rs2)) begin n_fail++; $display("FAIL %s wdata: got %h want %h", tag, dmem.wdata, exp_wdata(f3, rs2)); end
            end
         end
      end
      // DONE cycle (or IDLE again for a non-memory op)
      @(negedge clk);
      dmem.ack = 1'b0;
      #1;
      n_checks++; if (dmem.req !== 1'b0) begin n_fail++; $display("FAIL %s done_req: got %b want 0", tag, dmem.req); end
      n_checks++; if (stall_memory !== 1'b0) begin n_fail++; $display("FAIL %s done_stall: got %b want 0", tag, stall_memory); end
      n_checks++; if (rd_data_mw !== exp_rd) begin n_fail++; $display("FAIL %s rd_data_mw: got %h want %h", tag, rd_data_mw, exp_rd); end
      n_checks++; if (rdsel_mw !== rd) begin n_fail++; $display("FAIL %s rdsel_mw: got %h want %h", tag, rdsel_mw, rd); end
      n_checks++; if (decoded_op_mw !== op) begin n_fail++; $display("FAIL %s decoded_op_mw: got %h want %h", tag, decoded_op_mw, op); end
      n_checks++; if (curr_pc_mw !== pc) begin n_fail++; $display("FAIL %s curr_pc_mw: got %h want %h", tag, curr_pc_mw, pc); end
      n_checks++; if (alu_out_mw !== addr) begin n_fail++; $display("FAIL %s alu_out_mw: got %h want %h", tag, alu_out_mw, addr); end
      n_checks++; if (jump_state_mw !== jmp) begin n_fail++; $display("FAIL %s jump_state_mw: got %b want %b", tag, jump_state_mw, jmp); end
      n_checks++; if (misalign_mw !== trap) begin n_fail++; $display("FAIL %s misalign_mw: got %b want %b", tag, misalign_mw, trap); end
      @(negedge clk);
      phase_memory = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      // Present a load while in reset: nothing may start
      phase_memory = 1'b1;
      decoded_op_em = '0; decoded_op_em[LOAD_BIT] = 1'b1;
      alu_out_em = 32'h100;
      @(negedge clk); #1;
      n_checks++; if (dmem.req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", dmem.req); end
      n_checks++; if (rd_data_mw !== '0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", rd_data_mw); end
      n_checks++; if ({rdsel_mw, decoded_op_mw, curr_pc_mw, alu_out_mw, jump_state_mw} !== '0) begin n_fail++; $display("FAIL reset_mw_fields: got nonzero want 0"); end
      n_checks++; if (misalign_mw !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b want 0", misalign_mw); end
      phase_memory = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_alu_op();
      run_op("add", 1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'h0, 32'h0, 5'd7, 0, 1'b0);
   endtask

   task automatic test_loads();
      run_op("lw_100",  1'b1, 1'b0, FUNCT3_LW,  32'h100, 32'h0, 32'hDEAD_BEEF, 5'd1, 0, 1'b0);
      run_op("lb_103",  1'b1, 1'b0, FUNCT3_LB,  32'h103, 32'h0, 32'h80FF_FFFF, 5'd2, 0, 1'b0);
      run_op("lbu_103", 1'b1, 1'b0, FUNCT3_LBU, 32'h103, 32'h0, 32'h80FF_FFFF, 5'd3, 1, 1'b0);
      run_op("lh_102",  1'b1, 1'b0, FUNCT3_LH,  32'h102, 32'h0, 32'h9ABC_1234, 5'd4, 0, 1'b0);
      run_op("lhu_102", 1'b1, 1'b0, FUNCT3_LHU, 32'h102, 32'h0, 32'h9ABC_1234, 5'd5, 2, 1'b0);
      run_op("lunk",    1'b1, 1'b0, 3'b011,     32'h200, 32'h0, 32'h1357_9BDF, 5'd6, 0, 1'b0);
   endtask

   task automatic test_stores();
      run_op("sh_202", 1'b0, 1'b1, FUNCT3_LH, 32'h202, 32'h0000_ABCD, 32'h0, 5'd8, 3, 1'b0);
      run_op("sb_301", 1'b0, 1'b1, FUNCT3_LB, 32'h301, 32'h1234_5678, 32'h0, 5'd9, 0, 1'b0);
      run_op("sw_400", 1'b0, 1'b1, FUNCT3_LW, 32'h400, 32'hCAFE_F00D, 32'h0, 5'd10, 1, 1'b0);
   endtask

   task automatic test_misalign();
      // Trap build: no bus access, faulting address latched. Default build: access at 0x100.
      run_op("lw_102", 1'b1, 1'b0, FUNCT3_LW, 32'h102, 32'h0, 32'h0BAD_CAFE, 5'd11, 0, 1'b0);
      run_op("lh_101", 1'b1, 1'b0, FUNCT3_LH, 32'h101, 32'h0, 32'h8001_7F02, 5'd12, 0, 1'b0);
      // A following aligned op must clear the misalign flag
      run_op("after_mis", 1'b0, 1'b0, 3'd0, 32'h55, 32'h0, 32'h0, 5'd13, 0, 1'b0);
   endtask

   task automatic test_phase_drop();
      run_op("lw_drop", 1'b1, 1'b0, FUNCT3_LW, 32'h500, 32'h0, 32'h2468_ACE0, 5'd14, 2, 1'b1);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++)
         run_op("b2b", 1'b1, 1'b0, FUNCT3_LW, 32'h600 + 32'(4 * i), 32'h0, $urandom, 5'(i + 16), 0, 1'b0);
   endtask

   task automatic test_reset_mid_req();
      phase_memory = 1'b1;
      decoded_op_em = '0; decoded_op_em[LOAD_BIT] = 1'b1;
      decoded_op_em[FUNCT3_BIT_M:FUNCT3_BIT_L] = FUNCT3_LW;
      alu_out_em = 32'h40; dmem.ack = 1'b0;
      @(negedge clk); #1;
      n_checks++; if (dmem.req !== 1'b1) begin n_fail++; $display("FAIL midrst_req_before: got %b want 1", dmem.req); end
      rst_n = 1'b0; phase_memory = 1'b0;
      #1;
      n_checks++; if (dmem.req !== 1'b0) begin n_fail++; $display("FAIL midrst_req_drop: got %b want 0", dmem.req); end
      n_checks++; if (rd_data_mw !== '0) begin n_fail++; $display("FAIL midrst_rd_data: got %h want 0", rd_data_mw); end
      n_checks++; if ({rdsel_mw, decoded_op_mw, curr_pc_mw, alu_out_mw, jump_state_mw, misalign_mw} !== '0) begin n_fail++; $display("FAIL midrst_mw_fields: got nonzero want 0"); end
      @(negedge clk);
      rst_n = 1'b1;
      // Stray ack while idle must be ignored
      dmem.ack = 1'b1; dmem.rdata = 32'hFFFF_FFFF;
      @(negedge clk); #1;
      n_checks++; if (dmem.req !== 1'b0) begin n_fail++; $display("FAIL stray_ack_req: got %b want 0", dmem.req); end
      n_checks++; if (stall_memory !== 1'b0) begin n_fail++; $display("FAIL stray_ack_stall: got %b want 0", stall_memory); end
      n_checks++; if (rd_data_mw !== '0) begin n_fail++; $display("FAIL stray_ack_rd_data: got %h want 0", rd_data_mw); end
      dmem.ack = 1'b0;
      @(negedge clk);
      run_op("post_rst", 1'b1, 1'b0, FUNCT3_LB, 32'h41, 32'h0, 32'h0000_7F00, 5'd30, 0, 1'b0);
   endtask

   task automatic test_random();
      logic [2:0] load_f3 [6] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3};
      logic [2:0] store_f3 [3] = '{3'd0, 3'd1, 3'd2};
      for (int i = 0; i < 40; i++) begin
         int kind = $urandom_range(0, 2);
         logic [31:0] addr = $urandom;
         if (kind == 0)
            run_op("rnd_alu", 1'b0, 1'b0, 3'($urandom), addr, $urandom, 32'h0, 5'($urandom), 0, 1'b0);
         else if (kind == 1)
            run_op("rnd_load", 1'b1, 1'b0, load_f3[$urandom_range(0, 5)], addr, $urandom, $urandom,
                   5'($urandom), $urandom_range(0, 3), 1'($urandom));
         else
            run_op("rnd_store", 1'b0, 1'b1, store_f3[$urandom_range(0, 2)], addr, $urandom, $urandom,
                   5'($urandom), $urandom_range(0, 3), 1'($urandom));
      end
   endtask

   initial begin
      dmem.ack   = 1'b0;
      dmem.rdata = '0;
      test_reset();
      test_alu_op();
      test_loads();
      test_stores();
      test_misalign();
      test_phase_drop();
      test_back_to_back();
      test_reset_mid_req();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
